// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM states, FIFO entry layout
// and the default boot address.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the memory-side and decode-side signals of the fetch front-end.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   pcplus4;
    logic          instr_ready;
    logic [CW-1:0] count;

    // Handshakes: imem_req/imem_addr are held until the edge that samples imem_ack;
    // a decode transfer happens on every rising edge where instr_valid & instr_ready,
    // and instr/pcplus4 stay stable while instr_valid is high and not yet taken.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid, instr, pcplus4,
        input  instr_ready,
        output count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid, instr, pcplus4,
        output instr_ready,
        input  count
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; the head is read straight from the storage
// registers so decode never sees a combinational path from the memory bus.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop_i & (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // Flush wins over any push or pop presented in the same cycle.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: issues one word fetch at a time, buffers responses with their
// PC+4 and hands them to decode; a redirect flushes the buffer and orphans any pending fetch.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus,
    output fetch_state_e  dbg_state_o
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   addr_q;
    logic          req_q;

    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW-1:0] count;
    logic [CW:0]   count_next;
    logic [31:0]   pc_plus4;
    logic [31:0]   redirect_tgt;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign pc_plus4     = fetch_pc_q + 32'd4;
    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
    assign pop          = head_valid & bus.instr_ready;
    assign push         = (state_q == WAIT) & bus.imem_ack & ~bus.redirect;
    assign push_entry   = '{instr: bus.imem_rdata, pcplus4: pc_plus4};
    // Occupancy after this edge if the pending ack is pushed; decides back-to-back issue.
    assign count_next   = {1'b0, count} + CW1'(1) - CW1'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= redirect_tgt;
                    end else if (count < CW'(DEPTH)) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            fetch_pc_q <= redirect_tgt;
                            state_q    <= IDLE;
                            req_q      <= 1'b0;
                        end else begin
                            fetch_pc_q <= pc_plus4;
                            if (count_next < CW1'(DEPTH)) begin
                                addr_q <= pc_plus4;
                            end else begin
                                state_q <= IDLE;
                                req_q   <= 1'b0;
                            end
                        end
                    end else if (bus.redirect) begin
                        fetch_pc_q <= redirect_tgt;
                        state_q    <= DROP;
                    end
                end
                DROP: begin
                    // The stale request stays on the bus until memory answers it.
                    if (bus.redirect) begin
                        fetch_pc_q <= redirect_tgt;
                    end
                    if (bus.imem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (bus.redirect),
        .head_o  (head),
        .valid_o (head_valid),
        .count_o (count)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head.instr;
    assign bus.pcplus4     = head.pcplus4;
    assign bus.count       = count;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a randomly timed memory and decode drive the block while
// a queue-based model of the fetched stream checks every cycle.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] BOOT_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_state_e dbg_state;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (BOOT_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: in-order stream of {instr, pcplus4} that decode should see
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] cur_addr;
  bit outstanding, stale, last_redir;
  int idle_run, pushes, cyc;

  // stimulus knobs
  int ack_pct, ready_pct, redir_pct;
  bit force_ack, force_redir;
  logic [31:0] force_tgt;

  // observations from the latest cycle
  bit seen_valid, seen_req, new_req, did_ack;
  logic [31:0] seen_pc4, seen_addr;
  int seen_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc = BOOT_PC;
    outstanding = 0;
    stale = 0;
    last_redir = 0;
    idle_run = 0;
    cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, BOOT_PC);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pcplus4", bus.pcplus4, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock: compare at negedge, drive stimulus, advance the model at posedge.
  task automatic run_cycle();
    bit ack, rdy, redir, pop;
    logic [31:0] rdata, tgt;
    @(negedge clk);
    cyc++;
    seen_valid = bus.instr_valid;
    seen_req = bus.imem_req;
    seen_addr = bus.imem_addr;
    seen_pc4 = bus.pcplus4;
    seen_count = int'(bus.count);

    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("instr", bus.instr, exp_q[0][63:32]);
      chk("pcplus4", bus.pcplus4, exp_q[0][31:0]);
    end
    new_req = 0;
    if (outstanding) begin
      chk("req_held", 32'(bus.imem_req), 32'd1);
      chk("addr_held", bus.imem_addr, cur_addr);
    end else if (bus.imem_req) begin
      new_req = 1;
      chk("req_addr", bus.imem_addr, exp_pc);
      chk("req_room", 32'(exp_q.size() < DEPTH), 32'd1);
      outstanding = 1;
      stale = 0;
      cur_addr = exp_pc;
    end
    if (!bus.imem_req && exp_q.size() < DEPTH && !last_redir) idle_run++;
    else idle_run = 0;
    chk("fetch_live", 32'(idle_run <= 2), 32'd1);

    ack = outstanding && (force_ack || ($urandom_range(0, 99) < ack_pct));
    rdy = ($urandom_range(0, 99) < ready_pct);
    redir = force_redir || ($urandom_range(0, 99) < redir_pct);
    rdata = $urandom;
    if (force_redir) tgt = force_tgt;
    else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else tgt = 32'($urandom_range(0, 4095));
    force_ack = 0;
    force_redir = 0;

    bus.imem_ack = ack;
    bus.imem_rdata = rdata;
    bus.instr_ready = rdy;
    bus.redirect = redir;
    bus.redirect_pc = tgt;
    pop = (exp_q.size() != 0) && rdy;

    @(posedge clk);
    if (redir) begin
      exp_q.delete();
      exp_pc = {tgt[31:2], 2'b00};
      if (ack) outstanding = 0;
      else if (outstanding) stale = 1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (ack) begin
        outstanding = 0;
        if (!stale) begin
          if (exp_q.size() >= DEPTH) begin
            total++;
            bad++;
            $display("FAIL overflow: got push with %0d entries expected room", exp_q.size());
          end
          exp_q.push_back({rdata, cur_addr + 32'd4});
          exp_pc = cur_addr + 32'd4;
          pushes++;
        end
      end
    end
    did_ack = ack;
    last_redir = redir;
  endtask

  initial begin
    int addr_log[4];
    int n_log, first_valid, acks;
    bit count_ok, resumed, got_addr, got_valid;
    logic [31:0] first_addr, first_pc4;

    drive_idle();
    pushes = 0;
    force_ack = 0;
    force_redir = 0;
    force_tgt = '0;
    ack_pct = 100;
    ready_pct = 100;
    redir_pct = 0;
    model_reset();
    do_reset();

    // Streaming with single-cycle ack
    n_log = 0; first_valid = -1; count_ok = 1; acks = 0; first_pc4 = '0;
    for (int i = 0; i < 20; i++) begin
      run_cycle();
      if (new_req && n_log < 4) begin addr_log[n_log] = int'(seen_addr); n_log++; end
      if (seen_valid && first_valid < 0) begin first_valid = cyc; first_pc4 = seen_pc4; end
      if (cyc >= 3 && seen_count != 1) count_ok = 0;
      if (did_ack) acks++;
    end
    for (int i = 0; i < 4; i++) chk("stream_addr", 32'(addr_log[i]), 32'(4 * i));
    chk("first_valid_cycle", 32'(first_valid), 32'd2);
    chk("first_pcplus4", first_pc4, 32'd4);
    chk("steady_count_one", 32'(count_ok), 32'd1);
    chk("throughput", 32'(acks >= 19), 32'd1);

    // Decode stalled: FIFO fills and fetching stops
    ready_pct = 0; acks = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      if (did_ack) acks++;
    end
    chk("full_count", 32'(seen_count), 32'd4);
    chk("full_req_low", 32'(seen_req), 32'd0);
    chk("full_acks", 32'(acks), 32'd3);
    ready_pct = 100; resumed = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      if (new_req) resumed = 1;
    end
    chk("fetch_resumed", 32'(resumed), 32'd1);

    // Redirect while a fetch is pending, ack three cycles late
    ack_pct = 0;
    for (int i = 0; i < 10 && !outstanding; i++) run_cycle();
    chk("pending_before_redirect", 32'(outstanding), 32'd1);
    force_redir = 1; force_tgt = 32'h0000_0100;
    run_cycle();
    run_cycle();
    chk("redir_flushed_count", 32'(seen_count), 32'd0);
    chk("redir_flushed_valid", 32'(seen_valid), 32'd0);
    run_cycle();
    ack_pct = 100; got_addr = 0; got_valid = 0; first_addr = '0; first_pc4 = '0;
    for (int i = 0; i < 15; i++) begin
      run_cycle();
      if (new_req && !got_addr) begin got_addr = 1; first_addr = seen_addr; end
      if (seen_valid && !got_valid) begin got_valid = 1; first_pc4 = seen_pc4; end
    end
    chk("redir_next_addr", first_addr, 32'h0000_0100);
    chk("redir_first_pcplus4", first_pc4, 32'h0000_0104);

    // Redirect coinciding with ack, unaligned target
    ack_pct = 0;
    for (int i = 0; i < 10 && !outstanding; i++) run_cycle();
    force_ack = 1; force_redir = 1; force_tgt = 32'h0000_0203;
    run_cycle();
    chk("ack_redir_acked", 32'(did_ack), 32'd1);
    ack_pct = 100; got_addr = 0; first_addr = '0;
    run_cycle();
    chk("ack_redir_no_push", 32'(seen_count), 32'd0);
    if (new_req) begin got_addr = 1; first_addr = seen_addr; end
    for (int i = 0; i < 10 && !got_addr; i++) begin
      run_cycle();
      if (new_req) begin got_addr = 1; first_addr = seen_addr; end
    end
    chk("ack_redir_next_addr", first_addr, 32'h0000_0200);

    // Redirect plus pop with three entries buffered
    ready_pct = 0; ack_pct = 100;
    for (int i = 0; i < 12 && !(seen_count == 2 && did_ack); i++) run_cycle();
    ack_pct = 0; ready_pct = 100; force_redir = 1; force_tgt = 32'h0000_0400;
    run_cycle();
    chk("pre_flush_count", 32'(seen_count), 32'd3);
    run_cycle();
    chk("post_flush_count", 32'(seen_count), 32'd0);
    chk("post_flush_valid", 32'(seen_valid), 32'd0);

    // Reset while waiting on memory
    for (int i = 0; i < 10 && !outstanding; i++) run_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwait_req_drop", 32'(bus.imem_req), 32'd0);
    do_reset();
    ack_pct = 100; got_addr = 0; first_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (new_req && !got_addr) begin got_addr = 1; first_addr = seen_addr; end
    end
    chk("after_reset_addr", first_addr, BOOT_PC);

    // Random traffic
    for (int blk = 0; blk < 30; blk++) begin
      ack_pct = $urandom_range(20, 100);
      ready_pct = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 8);
      for (int i = 0; i < 100; i++) run_cycle();
    end
    chk("progress", 32'(pushes > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
